// File: rtl/cam_pkg.sv
// Shared definitions for the CAM command master.
// Holds the command opcode encoding, the FSM state encoding and small decode helpers
// that are used by cam_cmd_master.
package cam_pkg;

    // Command opcodes carried on cmd_op / rsp_op.
    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_RSVD   = 2'b11
    } cam_op_e;

    // Command sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_LK_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } cam_state_e;

    // True for the opcodes that modify CAM contents.
    function automatic logic op_is_write(input cam_op_e op);
        return (op == OP_INSERT) || (op == OP_DELETE);
    endfunction

endpackage

// File: rtl/cam_cmd_master.sv
// CAM command master.
// Accepts one command at a time on a valid/ready channel, drives the CAM write and
// compare ports, and returns one response per command on a valid/ready channel.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_op, cmd_addr, cmd_data payload
//   rsp_valid/rsp_ready          response handshake; rsp_op, rsp_hit, rsp_err, rsp_addr
//   write_enable, write_delete   one-cycle CAM write strobe and delete qualifier
//   write_addr, write_data       CAM write entry and key (held between writes)
//   compare_data                 CAM search key (held from lookup accept until response)
//   write_busy                   CAM is still completing a write
//   match, match_addr            CAM search result, valid MATCH_LATENCY cycles after accept
module cam_cmd_master
    import cam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned MATCH_LATENCY = 2,
    parameter int unsigned BUSY_TIMEOUT  = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_op,
    output logic                  rsp_hit,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  write_enable,
    output logic                  write_delete,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] compare_data,
    input  logic                  write_busy,
    input  logic                  match,
    input  logic [ADDR_WIDTH-1:0] match_addr
);

    localparam int unsigned ToW  = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned LatW = $clog2(MATCH_LATENCY + 1);

    // Last counter value before giving up on / sampling the CAM.
    localparam logic [ToW-1:0]  ToLast  = ToW'(BUSY_TIMEOUT - 1);
    localparam logic [LatW-1:0] LatLast = LatW'(MATCH_LATENCY - 1);

    cam_state_e            state_q, state_d;
    cam_op_e               op_q, op_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  write_delete_q, write_delete_d;
    logic [DATA_WIDTH-1:0] compare_data_q, compare_data_d;
    logic [ToW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [LatW-1:0]       lat_cnt_q, lat_cnt_d;
    cam_op_e               rsp_op_q, rsp_op_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;

    cam_op_e cmd_op_e;
    logic    cmd_accept;

    assign cmd_op_e = cam_op_e'(cmd_op);

    // Held low during reset so nothing is accepted in the reset cycle itself.
    assign cmd_ready  = (state_q == ST_IDLE) && !write_busy && !rst;
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        write_delete_d = write_delete_q;
        compare_data_d = compare_data_q;
        wait_cnt_d     = wait_cnt_q;
        lat_cnt_d      = lat_cnt_q;
        rsp_op_d       = rsp_op_q;
        rsp_hit_d      = rsp_hit_q;
        rsp_err_d      = rsp_err_q;
        rsp_addr_d     = rsp_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    op_d = cmd_op_e;
                    if (op_is_write(cmd_op_e)) begin
                        write_addr_d   = cmd_addr;
                        write_data_d   = cmd_data;
                        write_delete_d = (cmd_op_e == OP_DELETE);
                        wait_cnt_d     = '0;
                        state_d        = ST_WR_ISSUE;
                    end else if (cmd_op_e == OP_LOOKUP) begin
                        compare_data_d = cmd_data;
                        lat_cnt_d      = '0;
                        state_d        = ST_LK_WAIT;
                    end else begin
                        // Reserved opcode: answer at once, leave the CAM alone.
                        rsp_op_d   = OP_RSVD;
                        rsp_hit_d  = 1'b0;
                        rsp_err_d  = 1'b1;
                        rsp_addr_d = cmd_addr;
                        state_d    = ST_RESP;
                    end
                end
            end

            ST_WR_ISSUE: begin
                state_d = ST_WR_WAIT;
            end

            ST_WR_WAIT: begin
                // The CAM may not have raised write_busy yet on the first wait cycle,
                // so busy is only trusted from the second cycle onwards.
                if ((wait_cnt_q != '0) && !write_busy) begin
                    rsp_op_d   = op_q;
                    rsp_hit_d  = 1'b0;
                    rsp_err_d  = 1'b0;
                    rsp_addr_d = write_addr_q;
                    state_d    = ST_RESP;
                end else if (wait_cnt_q == ToLast) begin
                    rsp_op_d   = op_q;
                    rsp_hit_d  = 1'b0;
                    rsp_err_d  = 1'b1;
                    rsp_addr_d = write_addr_q;
                    state_d    = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_LK_WAIT: begin
                // compare_data was presented at accept; the result is valid in the
                // MATCH_LATENCY-th cycle of this state.
                if (lat_cnt_q == LatLast) begin
                    rsp_op_d   = OP_LOOKUP;
                    rsp_hit_d  = match;
                    rsp_err_d  = 1'b0;
                    rsp_addr_d = match_addr;
                    state_d    = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_LOOKUP;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            write_delete_q <= 1'b0;
            compare_data_q <= '0;
            wait_cnt_q     <= '0;
            lat_cnt_q      <= '0;
            rsp_op_q       <= OP_LOOKUP;
            rsp_hit_q      <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            write_delete_q <= write_delete_d;
            compare_data_q <= compare_data_d;
            wait_cnt_q     <= wait_cnt_d;
            lat_cnt_q      <= lat_cnt_d;
            rsp_op_q       <= rsp_op_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_err_q      <= rsp_err_d;
            rsp_addr_q     <= rsp_addr_d;
        end
    end

    // Strobe is decoded from state so it cannot assert anywhere but WR_ISSUE.
    assign write_enable = (state_q == ST_WR_ISSUE);
    assign write_delete = write_delete_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign compare_data = compare_data_q;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_op    = rsp_op_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_cam_cmd_master.sv
// Testbench for cam_cmd_master: a behavioural CAM stub on the CAM side, a table of
// directed vectors, a randomized phase scored against an array model of CAM contents,
// and hand-written reset sequences.
module tb_cam_cmd_master;
    import cam_pkg::*;

    localparam int TO = 1023;
    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [23:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic        rsp_hit;
    logic        rsp_err;
    logic [8:0]  rsp_addr;
    logic        write_enable;
    logic        write_delete;
    logic [8:0]  write_addr;
    logic [23:0] write_data;
    logic [23:0] compare_data;
    logic        write_busy;
    logic        match;
    logic [8:0]  match_addr;

    always #5 clk = ~clk;

    cam_cmd_master dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_op       (rsp_op),
        .rsp_hit      (rsp_hit),
        .rsp_err      (rsp_err),
        .rsp_addr     (rsp_addr),
        .write_enable (write_enable),
        .write_delete (write_delete),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .compare_data (compare_data),
        .write_busy   (write_busy),
        .match        (match),
        .match_addr   (match_addr)
    );

    // CAM stub: table written on write_enable, busy for busy_len cycles after each
    // write, search result valid MATCH_LATENCY (2) cycles after compare_data changes.
    bit   [23:0] stub_key [512];
    bit          stub_vld [512];
    logic [23:0] cmp_d1;
    int          busy_cnt = 0;
    int          busy_len = 0;

    always @(posedge clk) begin
        cmp_d1 <= compare_data;
        if (write_enable === 1'b1) begin
            if (write_delete === 1'b1) begin
                stub_vld[write_addr] <= 1'b0;
            end else begin
                stub_vld[write_addr] <= 1'b1;
                stub_key[write_addr] <= write_data;
            end
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign write_busy = (busy_cnt != 0);

    always_comb begin
        match      = 1'b0;
        match_addr = '0;
        for (int i = 511; i >= 0; i--) begin
            if (stub_vld[i] && (stub_key[i] == cmp_d1)) begin
                match      = 1'b1;
                match_addr = 9'(i);
            end
        end
    end

    // Write strobe monitor.
    int          pulse_cnt = 0;
    logic [8:0]  pulse_addr;
    logic [23:0] pulse_data;
    logic        pulse_del;

    always @(posedge clk) begin
        if (write_enable === 1'b1) begin
            pulse_cnt  <= pulse_cnt + 1;
            pulse_addr <= write_addr;
            pulse_data <= write_data;
            pulse_del  <= write_delete;
        end
    end

    // Reference model of CAM contents.
    logic [23:0] m_key [512];
    bit          m_vld [512];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_lookup(input logic [23:0] k, output logic hit,
                                         output logic [8:0] a);
        hit = 1'b0;
        a   = '0;
        for (int i = 0; i < 512; i++) begin
            if (m_vld[i] && (m_key[i] == k)) begin
                hit = 1'b1;
                a   = 9'(i);
                return;
            end
        end
    endfunction

    // Busy high for b cycles after the strobe; first idle cycle the master may act on
    // is the later of the third cycle after accept and the first non-busy cycle.
    function automatic int wr_lat(input int b, output logic err);
        int low;
        low = (b + 2 > 3) ? b + 2 : 3;
        err = (low - 1 > TO);
        return err ? TO + 2 : low + 1;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rsp_fields"}, 32'({rsp_op, rsp_hit, rsp_err, rsp_addr}), 32'd0);
        check({tag, ".wr_ctl"}, 32'({write_enable, write_delete, write_addr}), 32'd0);
        check({tag, ".write_data"}, 32'(write_data), 32'd0);
        check({tag, ".compare_data"}, 32'(compare_data), 32'd0);
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [23:0] data,
                          input int busy, input int rdy_dly, input logic exp_hit,
                          input logic exp_err, input logic [8:0] exp_addr, input int exp_lat,
                          input string tag);
        int          n;
        int          p0;
        logic        ok;
        logic [12:0] snap;
        logic [23:0] cmp0;
        logic [8:0]  waddr0;
        logic        is_wr;
        is_wr    = (op == OP_INSERT) || (op == OP_DELETE);
        busy_len = busy;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        cmp0      = compare_data;
        waddr0    = write_addr;
        p0        = pulse_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 9'($urandom);
        cmd_data  = 24'($urandom);
        if (op == OP_INSERT) begin
            m_key[addr] = data;
            m_vld[addr] = 1'b1;
        end else if (op == OP_DELETE) begin
            m_vld[addr] = 1'b0;
        end
        n  = 1;
        ok = 1'b1;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            if (op == OP_LOOKUP && compare_data !== data) ok = 1'b0;
            tick();
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".rsp_op"}, 32'(rsp_op), 32'(op));
        check({tag, ".rsp_hit"}, 32'(rsp_hit), 32'(exp_hit));
        check({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        if (op != OP_RSVD) check({tag, ".rsp_addr"}, 32'(rsp_addr), 32'(exp_addr));
        if (op == OP_LOOKUP)
            check({tag, ".cmp_hold"}, 32'(ok && (compare_data === data)), 32'd1);
        check({tag, ".pulses"}, 32'(pulse_cnt - p0), is_wr ? 32'd1 : 32'd0);
        if (is_wr) begin
            check({tag, ".pulse_addr"}, 32'(pulse_addr), 32'(addr));
            check({tag, ".pulse_data"}, 32'(pulse_data), 32'(data));
            check({tag, ".pulse_del"}, 32'(pulse_del), 32'(op == OP_DELETE));
        end
        if (op == OP_RSVD) begin
            check({tag, ".cam_untouched"}, 32'({compare_data === cmp0, write_addr === waddr0}),
                  32'd3);
        end
        if (rdy_dly > 0) begin
            snap      = {rsp_op, rsp_hit, rsp_err, rsp_addr};
            cmd_valid = 1'b1;
            cmd_op    = OP_LOOKUP;
            ok        = 1'b1;
            for (int i = 0; i < rdy_dly; i++) begin
                tick();
                if (rsp_valid !== 1'b1 || {rsp_op, rsp_hit, rsp_err, rsp_addr} !== snap ||
                    cmd_ready !== 1'b0) ok = 1'b0;
            end
            check({tag, ".stall_stable"}, 32'(ok), 32'd1);
        end
        // Offer a command in the same cycle the response is taken; it must not be taken.
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOOKUP;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(cmd_ready), 32'(!write_busy));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [8:0]  addr;
        logic [23:0] data;
        int          busy;
        int          rdy;
        logic        hit;
        logic        err;
        logic [8:0]  raddr;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        int          bad;
        logic        eh;
        logic        ee;
        logic [8:0]  ea;
        int          el;
        logic [1:0]  op;
        logic [8:0]  a;
        logic [23:0] d;
        int          b;
        int          r;
        logic [23:0] pool [6];

        vecs[0] = '{2'b01, 9'h005, 24'hABCDEF, 3,    0,  1'b0, 1'b0, 9'h005, 6};
        vecs[1] = '{2'b00, 9'h000, 24'hABCDEF, 0,    2,  1'b1, 1'b0, 9'h005, 3};
        vecs[2] = '{2'b01, 9'h1FF, 24'h123456, 0,    1,  1'b0, 1'b0, 9'h1FF, 4};
        vecs[3] = '{2'b00, 9'h000, 24'h123456, 0,    0,  1'b1, 1'b0, 9'h1FF, 3};
        vecs[4] = '{2'b10, 9'h005, 24'hABCDEF, 1,    0,  1'b0, 1'b0, 9'h005, 4};
        vecs[5] = '{2'b00, 9'h000, 24'hABCDEF, 0,    10, 1'b0, 1'b0, 9'h000, 3};
        vecs[6] = '{2'b11, 9'h0AA, 24'h000000, 0,    10, 1'b0, 1'b1, 9'h0AA, 1};
        vecs[7] = '{2'b01, 9'h010, 24'hABCDEF, 10,   0,  1'b0, 1'b0, 9'h010, 13};
        vecs[8] = '{2'b00, 9'h000, 24'hABCDEF, 0,    0,  1'b1, 1'b0, 9'h010, 3};
        vecs[9] = '{2'b01, 9'h020, 24'h555555, 1100, 0,  1'b0, 1'b1, 9'h020, 1025};

        pool[0] = 24'hABCDEF;
        pool[1] = 24'h123456;
        pool[2] = 24'h555555;
        pool[3] = 24'h000000;
        pool[4] = 24'hFFFFFF;
        pool[5] = 24'h0F0F0F;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();
        check("reset.release_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].busy, vecs[i].rdy,
                   vecs[i].hit, vecs[i].err, vecs[i].raddr, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // CAM still busy after the timed-out write: nothing may be accepted until it clears.
        n   = 0;
        bad = 0;
        while (write_busy && n < 200) begin
            if (cmd_ready !== 1'b0) bad++;
            tick();
            n++;
        end
        check("busy.ready_low", 32'(bad), 32'd0);
        check("busy.cleared", 32'(write_busy), 32'd0);
        check("busy.ready_back", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 99));
            op = (r < 40) ? OP_LOOKUP : (r < 70) ? OP_INSERT : (r < 90) ? OP_DELETE : OP_RSVD;
            a  = 9'($urandom_range(0, 15));
            d  = pool[$urandom_range(0, 5)];
            b  = int'($urandom_range(0, 6));
            ee = 1'b0;
            eh = 1'b0;
            ea = a;
            if (op == OP_LOOKUP) begin
                model_lookup(d, eh, ea);
                el = ML + 1;
            end else if (op == OP_RSVD) begin
                ee = 1'b1;
                el = 1;
            end else begin
                el = wr_lat(b, ee);
            end
            do_cmd(op, a, d, b, int'($urandom_range(0, 3)), eh, ee, ea, el,
                   $sformatf("rnd%0d", i));
        end

        // Reset while a lookup is waiting on the CAM: abandoned with no response.
        busy_len  = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOOKUP;
        cmd_data  = 24'h123456;
        tick();
        cmd_valid = 1'b0;
        rst       = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid !== 1'b0) bad++;
        end
        check("midrst.no_rsp", 32'(bad), 32'd0);
        check("midrst.ready", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_cmd_master.md
CAM_CMD_MASTER -- requirements
Module: cam_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: key width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: CAM entry address width.
REQ-003 SHALL have parameter MATCH_LATENCY, default 2: cycles from compare_data stable to a valid match/match_addr.
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 1023: maximum cycles spent waiting for write_busy to deassert.
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1: command offered.
REQ-008 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
REQ-009 SHALL have port cmd_op, input, 2: 00 lookup, 01 insert, 10 delete, 11 reserved.
REQ-010 SHALL have port cmd_addr, input, ADDR_WIDTH: entry for insert/delete.
REQ-011 SHALL have port cmd_data, input, DATA_WIDTH: key for insert/delete/lookup.
REQ-012 SHALL have port rsp_valid, output, 1: response held until rsp_ready.
REQ-013 SHALL have port rsp_ready, input, 1: response consumed.
REQ-014 SHALL have ports rsp_op (output, 2), rsp_hit (output, 1), rsp_err (output, 1) and rsp_addr (output, ADDR_WIDTH).
REQ-015 SHALL have CAM-side outputs write_enable (1), write_delete (1), write_addr (ADDR_WIDTH), write_data (DATA_WIDTH) and compare_data (DATA_WIDTH).
REQ-016 SHALL have CAM-side inputs write_busy (1), match (1) and match_addr (ADDR_WIDTH).

Function
REQ-017 SHALL implement FSM states IDLE, WR_ISSUE, WR_WAIT, LK_WAIT, RESP.
REQ-018 SHALL assert cmd_ready only in IDLE, and only when write_busy=0.
REQ-019 On accepting insert or delete, SHALL go to WR_ISSUE and register cmd_addr/cmd_data.
REQ-020 In WR_ISSUE, SHALL pulse write_enable for exactly one cycle, with write_delete=1 for delete and 0 for insert, then go to WR_WAIT.
REQ-021 In WR_WAIT, SHALL ignore write_busy on the first cycle, then go to RESP on the first cycle write_busy=0.
REQ-022 SHALL count cycles in WR_WAIT; on reaching BUSY_TIMEOUT, SHALL go to RESP with rsp_err=1.
REQ-023 On accepting a lookup, SHALL drive compare_data=cmd_data from the next cycle, go to LK_WAIT, and hold compare_data stable until RESP.
REQ-024 In LK_WAIT, after exactly MATCH_LATENCY cycles, SHALL sample match and match_addr into rsp_hit and rsp_addr, then go to RESP.
REQ-025 Command-accept to rsp_valid for a lookup SHALL be MATCH_LATENCY+1 cycles.
REQ-026 For insert/delete responses: rsp_hit=0, rsp_addr=registered cmd_addr, rsp_op=cmd_op.
REQ-027 A reserved op (11) SHALL be accepted and go directly to RESP with rsp_err=1 and rsp_hit=0, touching no CAM output.
REQ-028 In RESP, SHALL hold rsp_valid and all rsp_* stable until rsp_ready=1, then return to IDLE.
REQ-029 No new command SHALL be accepted in the cycle rsp_ready is taken; one command is outstanding at a time.
REQ-030 write_enable SHALL never assert outside WR_ISSUE.
REQ-031 write_addr/write_data SHALL hold their last value when idle.

Reset
REQ-032 On rst=1 at a clock edge, SHALL set: state=IDLE; cmd_ready=0 in that cycle; rsp_valid=0; rsp_hit=0; rsp_err=0; rsp_op=0; rsp_addr=0; write_enable=0; write_delete=0; write_addr=0; write_data=0; compare_data=0; timeout and latency counters=0.
REQ-033 Reset mid-operation SHALL abandon the in-flight command with no response; a write already pulsed is not retracted.

Structure
REQ-034 SHALL place the op encoding enum (OP_LOOKUP, OP_INSERT, OP_DELETE, OP_RSVD) and the FSM state enum in shared package cam_pkg.
REQ-035 SHALL be a single module with no sub-modules; the counter width is $clog2(BUSY_TIMEOUT+1).

Verification
REQ-036 Insert addr=0x005 data=0xABCDEF -> one-cycle write_enable, write_delete=0, write_addr=0x005; CAM busy 3 cycles -> rsp_valid, rsp_op=01, rsp_err=0.
REQ-037 After REQ-036, lookup 0xABCDEF -> rsp_valid 3 cycles after accept; rsp_hit=1, rsp_addr=0x005.
REQ-038 Delete addr=0x005, then lookup 0xABCDEF -> write_delete=1 on the pulse; lookup returns rsp_hit=0.
REQ-039 write_busy held high 1100 cycles -> rsp_err=1 after 1023 WR_WAIT cycles; cmd_ready stays 0 while busy.
REQ-040 rsp_ready held low 10 cycles -> rsp_* stable throughout, cmd_ready=0; op=11 -> immediate rsp_err=1 with no write_enable.
REQ-041 rst asserted in LK_WAIT -> all outputs at reset values the next cycle; no rsp_valid for the abandoned command.
